// File: rtl/mem_pingpong_arb.sv
// rtl/mem_pingpong_arb.sv - ping-pong block arbiter between a writer and a reader
//
// Purpose:
//   Arbitrates single-word accesses from a writer (deserializer side) and a
//   reader (serializer side) onto two memory blocks used as a ping-pong
//   buffer. The writer fills one block while the reader drains the other.
//   The blocks exchange roles when the fill block is complete and the drain
//   block is empty.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous active-high reset
//   wr_req     in   1   writer requests one access this cycle
//   wr_gnt     out  1   combinational write grant
//   rd_req     in   1   reader requests one access this cycle
//   rd_gnt     out  1   combinational read grant
//   memoryena  out  2   registered command: bit1 block (0=block1, 1=block2), bit0 1=write
//   mem_act    out  1   registered; memoryena/addr carry a live access
//   addr       out  AW  registered word address of the live access
//   bank_swap  out  1   registered one-cycle pulse when the blocks exchange roles
//   fill_bank  out  1   current fill block (0=block1, 1=block2)
//
// Optional feature:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, write/read contention alternates
//   between the two sides; otherwise the writer always wins contention.

module mem_pingpong_arb #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  output logic          wr_gnt,
  input  logic          rd_req,
  output logic          rd_gnt,
  output logic [1:0]    memoryena,
  output logic          mem_act,
  output logic [AW-1:0] addr,
  output logic          bank_swap,
  output logic          fill_bank
);

  // S_FILL: drain block empty, S_BOTH: both active, S_FULL: fill block complete
  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_BOTH = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          fill_bank_q, fill_bank_d;
  logic          bank_swap_q, bank_swap_d;
  logic [1:0]    ena_q, ena_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          act_q, act_d;
  logic          wr_elig, rd_elig, contend;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = the reader won the most recent contention
  logic          last_rd_q, last_rd_d;
`endif

  // Grant logic
  always_comb begin
    wr_elig = (state_q != S_FULL);
    rd_elig = (state_q != S_FILL);
    contend = wr_req && rd_req && wr_elig && rd_elig;
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    if (!rst) begin
      if (contend) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (last_rd_q) begin
          wr_gnt = 1'b1;
        end else begin
          rd_gnt = 1'b1;
        end
`else
        wr_gnt = 1'b1;
`endif
      end else begin
        wr_gnt = wr_req && wr_elig;
        rd_gnt = rd_req && rd_elig;
      end
    end
  end

  // Next-state, counters and registered memory command
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    fill_bank_d = fill_bank_q;
    bank_swap_d = 1'b0;
    ena_d       = ena_q;
    addr_d      = addr_q;
    act_d       = wr_gnt || rd_gnt;

    if (wr_gnt) begin
      ena_d  = {fill_bank_q, 1'b1};
      addr_d = wr_cnt_q;
      if (wr_cnt_q == LAST) begin
        if (state_q == S_FILL) begin
          // Drain block is empty: hand the full block straight to the reader
          state_d     = S_BOTH;
          fill_bank_d = ~fill_bank_q;
          wr_cnt_d    = '0;
          rd_cnt_d    = '0;
          bank_swap_d = 1'b1;
        end else begin
          // Reader still busy: park the writer, wr_cnt stays at LAST
          state_d = S_FULL;
        end
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (rd_gnt) begin
      ena_d  = {~fill_bank_q, 1'b0};
      addr_d = rd_cnt_q;
      if (rd_cnt_q == LAST) begin
        rd_cnt_d = '0;
        if (state_q == S_FULL) begin
          state_d     = S_BOTH;
          fill_bank_d = ~fill_bank_q;
          wr_cnt_d    = '0;
          bank_swap_d = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_rd_d = last_rd_q;
    if (contend && !rst) begin
      last_rd_d = rd_gnt;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      fill_bank_q <= 1'b0;
      bank_swap_q <= 1'b0;
      ena_q       <= 2'b00;
      addr_q      <= '0;
      act_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_rd_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      fill_bank_q <= fill_bank_d;
      bank_swap_q <= bank_swap_d;
      ena_q       <= ena_d;
      addr_q      <= addr_d;
      act_q       <= act_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_rd_q   <= last_rd_d;
`endif
    end
  end

  assign memoryena = ena_q;
  assign mem_act   = act_q;
  assign addr      = addr_q;
  assign bank_swap = bank_swap_q;
  assign fill_bank = fill_bank_q;

endmodule

// File: tb/tb_mem_pingpong_arb.sv
// tb/tb_mem_pingpong_arb.sv - self-checking bench for mem_pingpong_arb
module tb_mem_pingpong_arb;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req, rd_req;
  logic          wr_gnt, rd_gnt;
  logic [1:0]    memoryena;
  logic          mem_act;
  logic [AW-1:0] addr;
  logic          bank_swap;
  logic          fill_bank;

  mem_pingpong_arb #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .memoryena (memoryena),
    .mem_act   (mem_act),
    .addr      (addr),
    .bank_swap (bank_swap),
    .fill_bank (fill_bank)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a fill block with a word count, and a drain block that
  // either holds a complete block (with a read count) or is empty.
  bit         m_fb, m_davail, m_last_rd, m_act, m_swap, m_we, m_re, m_cont;
  int         m_fcnt, m_dcnt, m_addr;
  logic [1:0] m_ena;
  logic       g_wg, g_rg;

  task model_grant(input logic r, input logic w, input logic d);
    m_we   = !r && w && (m_fcnt < DEPTH);
    m_re   = !r && d && m_davail;
    m_cont = m_we && m_re;
    if (m_cont) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (m_last_rd) m_re = 1'b0;
      else           m_we = 1'b0;
`else
      m_re = 1'b0;
`endif
    end
  endtask

  task model_swap();
    m_fb     = ~m_fb;
    m_davail = 1'b1;
    m_fcnt   = 0;
    m_dcnt   = 0;
    m_swap   = 1'b1;
  endtask

  task model_clock(input logic r);
    if (r) begin
      m_fb = 0; m_davail = 0; m_last_rd = 1; m_act = 0; m_swap = 0;
      m_fcnt = 0; m_dcnt = 0; m_addr = 0; m_ena = 2'b00;
    end else begin
      m_swap = 1'b0;
      m_act  = m_we || m_re;
      if (m_cont) m_last_rd = m_re;
      if (m_we) begin
        m_ena  = {m_fb, 1'b1};
        m_addr = m_fcnt;
        m_fcnt++;
        if (m_fcnt == DEPTH && !m_davail) model_swap();
      end
      if (m_re) begin
        m_ena  = {~m_fb, 1'b0};
        m_addr = m_dcnt;
        m_dcnt++;
        if (m_dcnt == DEPTH) begin
          m_davail = 1'b0;
          m_dcnt   = 0;
          if (m_fcnt == DEPTH) model_swap();
        end
      end
    end
  endtask

  // One clock cycle: drive, check grants mid-cycle, check registered outputs after the edge
  task automatic step(input logic r, input logic w, input logic d, input string tag);
    rst = r; wr_req = w; rd_req = d;
    #1;
    model_grant(r, w, d);
    chk({tag, ".wr_gnt"}, wr_gnt, m_we);
    chk({tag, ".rd_gnt"}, rd_gnt, m_re);
    chk({tag, ".one_hot"}, wr_gnt & rd_gnt, 1'b0);
    g_wg = wr_gnt;
    g_rg = rd_gnt;
    @(posedge clk);
    model_clock(r);
    #1;
    chk({tag, ".mem_act"}, mem_act, m_act);
    chk({tag, ".bank_swap"}, bank_swap, m_swap);
    chk({tag, ".fill_bank"}, fill_bank, m_fb);
    if (m_act) begin
      chk({tag, ".memoryena"}, memoryena, m_ena);
      chk({tag, ".addr"}, addr, m_addr);
    end
  endtask

  typedef struct {
    logic       rst, wr, rd;
    logic       wg, rg;
    logic       act;
    logic [1:0] ena;
    logic [1:0] adr;
    logic       swap, fill;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [7:0] got_pat, exp_pat;
    int         pw, pr;

    //          rst   wr    rd    wg    rg    act   ena    adr   swap  fill
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd3, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'd1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'd2, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'd3, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 2'd1, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 2'd0, 1'b0, 1'b0};

    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;

    // Directed table: fill, drain, ineligible read, reset mid-fill
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.wg", i), g_wg, tbl[i].wg);
      chk($sformatf("tbl%0d.rg", i), g_rg, tbl[i].rg);
      chk($sformatf("tbl%0d.act", i), mem_act, tbl[i].act);
      chk($sformatf("tbl%0d.ena", i), memoryena, tbl[i].ena);
      chk($sformatf("tbl%0d.addr", i), addr, tbl[i].adr);
      chk($sformatf("tbl%0d.swap", i), bank_swap, tbl[i].swap);
      chk($sformatf("tbl%0d.fill", i), fill_bank, tbl[i].fill);
    end

    // Both requests held in S_BOTH
    step(1'b1, 1'b0, 1'b0, "seqA");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, "seqA");
    got_pat = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, "seqA");
      got_pat[i] = g_wg;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_pat = 8'b0101_0101;
`else
    exp_pat = 8'b0000_1111;
`endif
    chk("contend_pattern", got_pat, exp_pat);
    chk("contend_fill_bank", fill_bank, 1'b0);

    // S_FULL with the writer waiting: no write grant until the final read
    step(1'b1, 1'b0, 1'b0, "seqB");
    for (int i = 0; i < 2 * DEPTH; i++) step(1'b0, 1'b1, 1'b0, "seqB");
    chk("full_fill_bank", fill_bank, 1'b1);
    got_pat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b1, "seqB");
      got_pat[i] = g_wg;
      chk("full_rd_gnt", g_rg, 1'b1);
      chk("full_rd_addr", addr, i);
      chk("full_rd_ena", memoryena, 2'b00);
    end
    chk("full_no_wr_gnt", got_pat, 8'h00);
    chk("full_swap", bank_swap, 1'b1);
    chk("full_fill_toggled", fill_bank, 1'b0);
    step(1'b0, 1'b1, 1'b1, "seqB");
    chk("resume_wr_gnt", g_wg, 1'b1);
    chk("resume_addr", addr, 0);
    chk("resume_ena", memoryena, 2'b01);

    // Randomized traffic against the model
    step(1'b1, 1'b0, 1'b0, "rnd");
    for (int blk = 0; blk < 10; blk++) begin
      pw = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      for (int i = 0; i < 80; i++) begin
        step($urandom_range(0, 99) == 0,
             $urandom_range(0, 99) < pw,
             $urandom_range(0, 99) < pr, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
